fpu_add_scheduler: RTL

Shares one pipelined single-precision floating-point adder between N_REQ requesters.
- Round-robin arbitration, one operand pair issued per cycle.
- Tracks each in-flight operation's requester ID through a tag pipeline matched to adder latency, and routes each result and status back to its owner.
- Provides a flush/drain sequence and a sticky protocol-error flag. Sits between the FPU clients and floating_point_adder.

---
 rtl/fpu_sched_pkg.sv | 27 ++
 rtl/fpu_add_scheduler_if.sv | 36 +++
 rtl/rr_arbiter.sv | 25 ++
 rtl/shift_reg_base.sv | 30 +++
 rtl/fpu_add_scheduler.sv | 134 +++++++++++++
 5 files changed

// File: rtl/fpu_sched_pkg.sv
// Shared types for the FPU adder scheduler: FSM states, adder status codes
// and the tag carried alongside each in-flight add.
package fpu_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } sched_state_e;

    typedef enum logic [1:0] {
        OK  = 2'b00,
        NAN = 2'b01,
        INF = 2'b10,
        NUL = 2'b11
    } fp_status_e;

    // Sized for the largest supported requester count (8); narrower
    // configurations zero-extend their requester index into it.
    localparam int TAG_ID_W = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/fpu_add_scheduler_if.sv
// Bundle of client-side and adder-side signals around the scheduler.
// Handshake: a request transfers on any rising clk where req_vld[i] && req_rdy[i];
// a requester holding req_vld keeps req_a/req_b stable until it transfers.
// rsp_vld and add_res_vld are pure strobes with no backpressure.
interface fpu_add_scheduler_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req_vld;
    logic [N_REQ*32-1:0] req_a;
    logic [N_REQ*32-1:0] req_b;
    logic [N_REQ-1:0]    req_rdy;
    logic                flush;
    logic                flush_done;
    logic [31:0]         add_a;
    logic [31:0]         add_b;
    logic                add_arg_vld;
    logic [31:0]         add_result;
    logic [1:0]          add_state;
    logic                add_res_vld;
    logic [N_REQ-1:0]    rsp_vld;
    logic [31:0]         rsp_result;
    logic [1:0]          rsp_state;
    logic                err;

    modport slave (
        input  req_vld, req_a, req_b, flush, add_result, add_state, add_res_vld,
        output req_rdy, flush_done, add_a, add_b, add_arg_vld,
               rsp_vld, rsp_result, rsp_state, err
    );

    modport master (
        output req_vld, req_a, req_b, flush, add_result, add_state, add_res_vld,
        input  req_rdy, flush_done, add_a, add_b, add_arg_vld,
               rsp_vld, rsp_result, rsp_state, err
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant, search begins at the
// requester after last_grant and wraps.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic                     en,
    input  logic [$clog2(N_REQ)-1:0] last_grant,
    output logic [N_REQ-1:0]         grant
);
    always_comb begin
        int   idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_grant) + k) % N_REQ;
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/shift_reg_base.sv
// Resettable fixed-depth shift register. The MSB of every stage is also
// exposed so callers can treat it as an occupancy flag.
module shift_reg_base #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [DEPTH-1:0] msb_taps
);
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

    always_comb begin
        msb_taps = '0;
        for (int i = 0; i < DEPTH; i++) msb_taps[i] = stage[i][WIDTH-1];
    end
endmodule

// File: rtl/fpu_add_scheduler.sv
// Shares one pipelined FP adder among N_REQ requesters: round-robin issue,
// requester-ID tag pipe matched to adder latency, result routing, flush/drain.
module fpu_add_scheduler
    import fpu_sched_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int LATENCY      = 7,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    fpu_add_scheduler_if.slave    bus,
    output sched_state_e          state_dbg
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam int TAG_W = 1 + ID_W;

    sched_state_e     state;
    logic [ID_W-1:0]  last_grant;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  issue_id;
    logic [CNT_W-1:0] inflight;
    logic             grant_en;
    logic             transfer;
    logic [TAG_W-1:0] tag_q;
    logic [LATENCY-1:0] tag_taps;
    logic             pipe_busy;
    tag_t             tag_out;

    // Flush gates grants in the same cycle it is raised, not one cycle later.
    assign grant_en = (state == RUN) && !bus.flush && (inflight < CNT_W'(MAX_INFLIGHT));

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req        (bus.req_vld),
        .en         (grant_en),
        .last_grant (last_grant),
        .grant      (bus.req_rdy)
    );

    assign transfer  = |(bus.req_vld & bus.req_rdy);
    assign state_dbg = state;

    always_comb begin
        grant_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.req_rdy[i]) grant_id = ID_W'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.add_arg_vld <= 1'b0;
            bus.add_a       <= '0;
            bus.add_b       <= '0;
            issue_id        <= '0;
            last_grant      <= '0;
        end else begin
            bus.add_arg_vld <= transfer;
            if (transfer) begin
                bus.add_a  <= bus.req_a[32*int'(grant_id) +: 32];
                bus.add_b  <= bus.req_b[32*int'(grant_id) +: 32];
                issue_id   <= grant_id;
                last_grant <= grant_id;
            end
        end
    end

    shift_reg_base #(.WIDTH(TAG_W), .DEPTH(LATENCY)) u_tag_pipe (
        .clk      (clk),
        .rst      (rst),
        .d        ({bus.add_arg_vld, issue_id}),
        .q        (tag_q),
        .msb_taps (tag_taps)
    );

    always_comb begin
        tag_out.valid = tag_q[TAG_W-1];
        tag_out.id    = TAG_ID_W'(tag_q[ID_W-1:0]);
    end

    assign pipe_busy = bus.add_arg_vld | (|tag_taps);

    // Responses follow the tag, not add_res_vld: a missing result is still
    // delivered to its owner, and an untagged result is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_vld    <= '0;
            bus.rsp_result <= '0;
            bus.rsp_state  <= OK;
            bus.err        <= 1'b0;
        end else begin
            bus.rsp_vld <= '0;
            if (tag_out.valid) begin
                bus.rsp_vld    <= N_REQ'(1) << tag_out.id;
                bus.rsp_result <= bus.add_result;
                bus.rsp_state  <= bus.add_state;
            end
            if (bus.add_res_vld != tag_out.valid) bus.err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            unique case ({transfer, tag_out.valid})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   if (inflight != '0) inflight <= inflight - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            bus.flush_done <= 1'b0;
        end else begin
            bus.flush_done <= 1'b0;
            unique case (state)
                IDLE:  if (!bus.flush) state <= RUN;
                RUN:   if (bus.flush) state <= DRAIN;
                DRAIN: begin
                    if (inflight == '0 && !pipe_busy) begin
                        state          <= IDLE;
                        bus.flush_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
